// File: rtl/flash_rd_sched.sv
// Flash read scheduler: six audio reads per sample tick for three wavetable
// voices, with single-word host reads served in the idle gaps.
module flash_rd_sched #(
    parameter int asz    = 24,
    parameter int dsz    = 16,
    parameter int RD_LAT = 4,
    parameter int HOLD   = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ena,
    output logic [1:0]     cyc_num,
    input  logic [asz-1:0] wg_addr,
    output logic           data_stb,
    output logic [dsz-1:0] wg_data,
    input  logic           host_req,
    input  logic [asz-1:0] host_addr,
    output logic           host_ack,
    output logic [dsz-1:0] host_rdata,
    output logic [asz-1:0] fl_addr,
    output logic           fl_ce_n,
    output logic           fl_oe_n,
    input  logic [dsz-1:0] fl_data,
    output logic           overrun
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOST_RD = 3'd1,
        WV_RD0  = 3'd2,
        WV_RD1  = 3'd3,
        WV_HOLD = 3'd4
    } state_t;

    localparam logic [7:0] LAT_C  = 8'(RD_LAT);
    localparam logic [7:0] TURN_C = 8'(RD_LAT + 1);
    localparam logic [7:0] HOLD_C = 8'(HOLD - 1);

    state_t         state, state_d;
    logic [7:0]     cnt, cnt_d;
    logic [1:0]     slot, slot_d;
    logic           pend, pend_d;

    logic [asz-1:0] fl_addr_d;
    logic           fl_ce_n_d;
    logic           data_stb_d;
    logic [dsz-1:0] wg_data_d;
    logic           host_ack_d;
    logic [dsz-1:0] host_rdata_d;
    logic           overrun_d;

    logic           in_rd;
    logic           in_wv;
    logic           abort;
    logic           rd_go;
    logic           rd_cap;
    logic [10:0]    idx_nx;
    logic [asz-1:0] nx;

    assign in_rd  = (state == HOST_RD) || (state == WV_RD0) || (state == WV_RD1);
    assign in_wv  = (state == WV_RD0) || (state == WV_RD1) || (state == WV_HOLD);
    assign abort  = in_wv && ena;
    assign rd_go  = in_rd && (cnt == 8'd0);
    assign rd_cap = in_rd && (cnt == LAT_C);

    // Next sample stays inside the same wave: only the 11-bit index advances.
    assign idx_nx = {wg_addr[12:10], wg_addr[8:1]} + 11'd1;
    assign nx     = {wg_addr[asz-1:13], idx_nx[10:8], 1'b0, idx_nx[7:0], 1'b0};

    assign cyc_num = in_wv ? slot : 2'b11;
    assign fl_oe_n = fl_ce_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            slot       <= '0;
            pend       <= 1'b0;
            fl_addr    <= '0;
            fl_ce_n    <= 1'b1;
            data_stb   <= 1'b0;
            wg_data    <= '0;
            host_ack   <= 1'b0;
            host_rdata <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            slot       <= slot_d;
            pend       <= pend_d;
            fl_addr    <= fl_addr_d;
            fl_ce_n    <= fl_ce_n_d;
            data_stb   <= data_stb_d;
            wg_data    <= wg_data_d;
            host_ack   <= host_ack_d;
            host_rdata <= host_rdata_d;
            overrun    <= overrun_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        slot_d  = slot;
        pend_d  = pend;
        unique case (state)
            IDLE: begin
                if (ena || pend) begin
                    state_d = WV_RD0;
                    slot_d  = 2'd0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else if (host_req) begin
                    state_d = HOST_RD;
                    cnt_d   = '0;
                end
            end
            HOST_RD: begin
                // Host reads are atomic; a tick arriving now is replayed from IDLE.
                if (ena) pend_d = 1'b1;
                if (cnt == TURN_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            WV_RD0: begin
                if (rd_cap) begin
                    state_d = WV_RD1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            WV_RD1: begin
                if (rd_cap) begin
                    state_d = WV_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            WV_HOLD: begin
                if (cnt == HOLD_C) begin
                    cnt_d = '0;
                    if (slot == 2'd2) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WV_RD0;
                        slot_d  = slot + 2'd1;
                    end
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort) begin
            state_d = WV_RD0;
            slot_d  = 2'd0;
            cnt_d   = '0;
        end
    end

    always_comb begin
        fl_addr_d    = fl_addr;
        fl_ce_n_d    = 1'b1;
        data_stb_d   = 1'b0;
        wg_data_d    = wg_data;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata;
        overrun_d    = 1'b0;
        if (rd_go) begin
            unique case (1'b1)
                state == HOST_RD: fl_addr_d = host_addr;
                state == WV_RD1:  fl_addr_d = nx;
                default:          fl_addr_d = wg_addr;
            endcase
        end
        if (in_rd && (cnt < LAT_C)) fl_ce_n_d = 1'b0;
        if (rd_cap) begin
            if (state == HOST_RD) begin
                host_rdata_d = fl_data;
                host_ack_d   = 1'b1;
            end else begin
                wg_data_d  = fl_data;
                data_stb_d = 1'b1;
            end
        end
        if (abort) begin
            fl_addr_d  = fl_addr;
            fl_ce_n_d  = 1'b1;
            data_stb_d = 1'b0;
            wg_data_d  = wg_data;
            overrun_d  = 1'b1;
        end
    end

endmodule

// File: tb/tb_flash_rd_sched.sv
// Bench for flash_rd_sched: flash memory model, wavegen address table and
// a pass-level reference for strobe order, addresses, data and timing.
module tb_flash_rd_sched;

    localparam int LAT  = 4;
    localparam int HOLD = 6;
    localparam int PER  = LAT + 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ena;
    logic [1:0]  cyc_num;
    logic [23:0] wg_addr;
    logic        data_stb;
    logic [15:0] wg_data;
    logic        host_req;
    logic [23:0] host_addr;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic [23:0] fl_addr;
    logic        fl_ce_n;
    logic        fl_oe_n;
    logic [15:0] fl_data;
    logic        overrun;

    always #5 clk = ~clk;

    flash_rd_sched #(.asz(24), .dsz(16), .RD_LAT(LAT), .HOLD(HOLD)) dut (
        .clk(clk), .reset_n(reset_n), .ena(ena), .cyc_num(cyc_num),
        .wg_addr(wg_addr), .data_stb(data_stb), .wg_data(wg_data),
        .host_req(host_req), .host_addr(host_addr), .host_ack(host_ack),
        .host_rdata(host_rdata), .fl_addr(fl_addr), .fl_ce_n(fl_ce_n),
        .fl_oe_n(fl_oe_n), .fl_data(fl_data), .overrun(overrun)
    );

    function automatic logic [15:0] word(input logic [23:0] a);
        return a[15:0] ^ {a[23:16], a[7:0]} ^ 16'h5A3C;
    endfunction

    function automatic logic [23:0] nx_ref(input logic [23:0] a);
        int idx;
        idx = ((int'(a) >> 10) & 7) * 256 + ((int'(a) >> 1) & 255);
        idx = (idx + 1) % 2048;
        return (a & 24'hFFE000) | 24'((idx / 256) << 10) | 24'((idx % 256) << 1);
    endfunction

    logic [23:0] wt [3];
    always_comb wg_addr = (cyc_num == 2'd3) ? 24'h0 : wt[cyc_num];
    assign fl_data = fl_ce_n ? 16'hDEAD : word(fl_addr);

    typedef struct {
        int          cyc;
        logic [1:0]  slot;
        logic [15:0] data;
        logic [23:0] addr;
    } stb_t;

    stb_t        sq [$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          passes_done = 0;
    int          idle_cyc = 0;
    int          ack_cnt = 0;
    int          ov_cnt = 0;
    int          ov_cyc = 0;
    int          viol = 0;
    logic [23:0] last_rd_addr = '0;
    logic [1:0]  prev_cn = 2'd3;
    logic        prev_ce = 1'b1;
    logic [23:0] prev_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_stb) sq.push_back('{cyc, cyc_num, wg_data, fl_addr});
        if (host_ack) ack_cnt++;
        if (overrun) begin
            ov_cnt++;
            ov_cyc = cyc;
        end
        if (prev_cn != 2'd3 && cyc_num == 2'd3) begin
            passes_done++;
            idle_cyc = cyc;
        end
        if (prev_ce && !fl_ce_n) last_rd_addr = fl_addr;
        if (!prev_ce && !fl_ce_n && (cyc_num != prev_cn || fl_addr != prev_addr)) viol++;
        if (fl_oe_n !== fl_ce_n) viol++;
        prev_cn   = cyc_num;
        prev_ce   = fl_ce_n;
        prev_addr = fl_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fire_ena(output int e);
        ena = 1'b1;
        e   = cyc + 1;
        tick();
        ena = 1'b0;
    endtask

    task automatic wait_pass(input int pd);
        for (int n = 0; n < 400 && passes_done == pd; n++) tick();
        chk("pass_done", passes_done, pd + 1);
    endtask

    // Six strobes: slot s reads wt[s] then its next-sample address.
    task automatic check_pass(input int e, input int off, input int i0);
        int          base;
        logic [23:0] ea;
        base = e + off - PER;
        chk("n_stb", sq.size() - i0, 6);
        for (int k = 0; k < 6; k++) begin
            if (i0 + k < sq.size()) begin
                ea = (k % 2 == 1) ? nx_ref(wt[k / 2]) : wt[k / 2];
                chk("stb_slot", sq[i0 + k].slot, k / 2);
                chk("stb_addr", sq[i0 + k].addr, ea);
                chk("stb_data", sq[i0 + k].data, word(ea));
                chk("stb_cyc", sq[i0 + k].cyc, base + PER * (k + 1) + HOLD * (k / 2));
            end
        end
        chk("pass_end", idle_cyc, base + 6 * PER + 3 * HOLD);
    endtask

    task automatic host_rd(input logic [23:0] a);
        int r;
        int a0;
        a0        = ack_cnt;
        host_addr = a;
        host_req  = 1'b1;
        r         = cyc + 1;
        for (int n = 0; n < 50 && !host_ack; n++) tick();
        host_req = 1'b0;
        chk("host_lat", cyc - r, PER);
        chk("host_rdata", host_rdata, word(a));
        chk("host_fl_addr", last_rd_addr, a);
        repeat (3) tick();
        chk("host_ack_cnt", ack_cnt - a0, 1);
    endtask

    initial begin
        int e, e2, pd, i0, r, npre, cnt_pre, ov0;
        reset_n   = 1'b0;
        ena       = 1'b0;
        host_req  = 1'b0;
        host_addr = '0;
        for (int i = 0; i < 3; i++) wt[i] = 24'($urandom());
        repeat (3) tick();
        chk("rst_cyc_num", cyc_num, 2'b11);
        chk("rst_ce", fl_ce_n, 1'b1);
        chk("rst_oe", fl_oe_n, 1'b1);
        chk("rst_stb", data_stb, 1'b0);
        chk("rst_wg_data", wg_data, 16'h0);
        chk("rst_ack", host_ack, 1'b0);
        chk("rst_rdata", host_rdata, 16'h0);
        chk("rst_fl_addr", fl_addr, 24'h0);
        chk("rst_overrun", overrun, 1'b0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Idle pass with index-wrap addresses in slots 0 and 1.
        wt[0] = 24'h00BFFF;
        wt[1] = 24'h0061FE;
        wt[2] = 24'($urandom());
        pd = passes_done;
        i0 = sq.size();
        fire_ena(e);
        wait_pass(pd);
        check_pass(e, PER, i0);
        chk("pass_len", idle_cyc - e + 1, 6 * PER + 3 * HOLD + 1);
        chk("wrap_7ff", sq[i0 + 1].addr, 24'h00A000);
        chk("wrap_0ff", sq[i0 + 3].addr, 24'h006400);
        repeat (4) tick();

        host_rd(24'h123456);
        repeat ($urandom_range(2, 6)) tick();

        // Host request two cycles ahead of the tick.
        pd = passes_done;
        i0 = sq.size();
        host_addr = 24'($urandom());
        host_req  = 1'b1;
        r = cyc + 1;
        tick();
        tick();
        fire_ena(e);
        for (int n = 0; n < 50 && !host_ack; n++) tick();
        host_req = 1'b0;
        chk("hp_ack_lat", cyc - r, PER);
        chk("hp_rdata", host_rdata, word(host_addr));
        wait_pass(pd);
        check_pass(e, 2 * PER, i0);
        repeat (4) tick();

        // Random passes, each with a host request raised mid-pass.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 3; i++) wt[i] = 24'($urandom());
            pd = passes_done;
            i0 = sq.size();
            fire_ena(e);
            repeat ($urandom_range(3, 30)) tick();
            host_addr = 24'($urandom());
            host_req  = 1'b1;
            for (int n = 0; n < 200 && !host_ack; n++) tick();
            host_req = 1'b0;
            chk("hw_ack_cyc", cyc, e + 6 * PER + 3 * HOLD + 1 + PER);
            chk("hw_rdata", host_rdata, word(host_addr));
            chk("hw_pass", passes_done, pd + 1);
            check_pass(e, PER, i0);
            repeat ($urandom_range(2, 8)) tick();
            host_rd(24'($urandom()));
        end

        // Overrun: second tick 20 cycles into the pass.
        pd  = passes_done;
        i0  = sq.size();
        ov0 = ov_cnt;
        fire_ena(e);
        repeat (19) tick();
        fire_ena(e2);
        wait_pass(pd);
        npre = 0;
        for (int k = 0; k < 6; k++)
            if (e + PER * (k + 1) + HOLD * (k / 2) < e2) npre++;
        cnt_pre = 0;
        for (int k = i0; k < sq.size(); k++)
            if (sq[k].cyc < e2) cnt_pre++;
        chk("ov_pre_stb", cnt_pre, npre);
        chk("ov_cnt", ov_cnt - ov0, 1);
        chk("ov_cyc", ov_cyc, e2);
        check_pass(e2, PER, i0 + npre);
        repeat (4) tick();

        // Reset pulse while the second read of slot 0 is in flight.
        i0 = sq.size();
        fire_ena(e);
        repeat (7) tick();
        reset_n = 1'b0;
        tick();
        chk("mrst_cyc_num", cyc_num, 2'b11);
        chk("mrst_ce", fl_ce_n, 1'b1);
        chk("mrst_stb", data_stb, 1'b0);
        reset_n = 1'b1;
        repeat (20) tick();
        chk("mrst_nostb", sq.size() - i0, 1);
        for (int i = 0; i < 3; i++) wt[i] = 24'($urandom());
        pd = passes_done;
        i0 = sq.size();
        fire_ena(e);
        wait_pass(pd);
        check_pass(e, PER, i0);
        repeat (4) tick();

        chk("ce_low_stable", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
